// File: rtl/pla_vector_driver.sv
// Stimulus sequencer for a combinational PLA. It applies counter or LFSR vectors,
// waits for the PLA outputs to settle, then folds each response into a MISR signature.
module pla_vector_driver #(
    parameter int IN_W       = 21,
    parameter int OUT_W      = 23,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [IN_W-1:0]  seed,
    input  logic [IN_W:0]    count,
    output logic [IN_W-1:0]  x_out,
    input  logic [OUT_W-1:0] z_in,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic [IN_W:0]    vec_idx
);

    // state  | meaning
    // IDLE   | waiting for start; results from the last run stay readable
    // SETTLE | stimulus held while the PLA outputs settle
    // SAMPLE | response folded into the MISR, stimulus advanced
    // DONE   | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [OUT_W-1:0] POLY        = OUT_W'(23'h000021);
    localparam logic [IN_W-1:0]  TAPS        = IN_W'(21'h000005);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t             state, state_n;
    logic [3:0]         settle_cnt, settle_cnt_n;
    logic               mode_q, mode_n;
    logic [IN_W:0]      count_q, count_n;
    logic [IN_W-1:0]    x_n, x_step;
    logic [OUT_W-1:0]   sig_n, sig_step;
    logic [IN_W:0]      idx_n, idx_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            mode_q     <= 1'b0;
            count_q    <= '0;
            x_out      <= '0;
            signature  <= '0;
            vec_idx    <= '0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_cnt_n;
            mode_q     <= mode_n;
            count_q    <= count_n;
            x_out      <= x_n;
            signature  <= sig_n;
            vec_idx    <= idx_n;
        end
    end

    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        mode_n       = mode_q;
        count_n      = count_q;
        x_n          = x_out;
        sig_n        = signature;
        idx_n        = vec_idx;

        x_step   = mode_q ? ({x_out[IN_W-2:0], 1'b0} ^ (x_out[IN_W-1] ? TAPS : '0))
                          : x_out + 1'b1;
        sig_step = ({signature[OUT_W-2:0], 1'b0} ^ (signature[OUT_W-1] ? POLY : '0)) ^ z_in;
        idx_inc  = vec_idx + 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    // an all-zero LFSR would never leave zero
                    x_n          = (mode && seed == '0) ? IN_W'(1) : seed;
                    sig_n        = '0;
                    idx_n        = '0;
                    settle_cnt_n = SETTLE_LOAD;
                    mode_n       = mode;
                    count_n      = count;
                    state_n      = (count == '0) ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) state_n = SAMPLE;
                else                  settle_cnt_n = settle_cnt - 1'b1;
            end
            SAMPLE: begin
                sig_n = sig_step;
                x_n   = x_step;
                idx_n = idx_inc;
                if (idx_inc == count_q) begin
                    state_n = DONE;
                end else begin
                    state_n      = SETTLE;
                    settle_cnt_n = SETTLE_LOAD;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // abort discards any pending SAMPLE update
        if (abort && state != IDLE) begin
            state_n      = IDLE;
            settle_cnt_n = settle_cnt;
            x_n          = x_out;
            sig_n        = signature;
            idx_n        = vec_idx;
        end
    end

    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_pla_vector_driver.sv
// Randomized bench for pla_vector_driver; expected results come from a
// vector-list model of the run (stimulus sequence, MISR fold, cycle formula).
module tb_pla_vector_driver;
    localparam int IN_W = 21;
    localparam int OUT_W = 23;
    localparam int SC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, mode = 1'b0;
    logic [IN_W-1:0]  seed = '0;
    logic [IN_W:0]    count = '0;
    logic [IN_W-1:0]  x_out;
    logic [OUT_W-1:0] z_in, signature;
    logic [IN_W:0]    vec_idx;
    logic             busy, done;

    bit               zsel = 1'b0;
    logic [OUT_W-1:0] z_const = 23'h000001;

    int errors = 0;
    int checks = 0;

    pla_vector_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .seed(seed), .count(count), .x_out(x_out), .z_in(z_in), .busy(busy),
        .done(done), .signature(signature), .vec_idx(vec_idx)
    );

    always #5 clk = ~clk;

    // stand-in PLA: an arbitrary fixed combinational map of the stimulus
    function automatic logic [OUT_W-1:0] pla_fn(input logic [IN_W-1:0] x);
        return {x, 2'b01} ^ {2'b10, x ^ 21'h0f0f0f};
    endfunction

    assign z_in = zsel ? pla_fn(x_out) : z_const;

    // reference: list of vectors applied, each response folded into the MISR
    task automatic model(input logic m, input logic [IN_W-1:0] s, input int n,
                         output logic [OUT_W-1:0] sig, output logic [IN_W-1:0] x,
                         output int idx);
        longint unsigned xv, sv, zv;
        xv = (m && s == 0) ? 1 : s;
        sv = 0;
        for (int i = 0; i < n; i++) begin
            zv = zsel ? pla_fn(xv[IN_W-1:0]) : z_const;
            sv = (((sv * 2) % (1 << OUT_W)) ^ ((sv >> (OUT_W - 1)) != 0 ? 'h21 : 0)) ^ zv;
            if (m) xv = ((xv * 2) % (1 << IN_W)) ^ ((xv >> (IN_W - 1)) != 0 ? 'h5 : 0);
            else   xv = (xv + 1) % (1 << IN_W);
        end
        sig = sv[OUT_W-1:0];
        x   = xv[IN_W-1:0];
        idx = n;
    endtask

    // leaves time at #1 after the start edge, i.e. inside cycle 1
    task automatic start_run(input logic m, input logic [IN_W-1:0] s, input logic [IN_W:0] c);
        @(negedge clk);
        mode = m; seed = s; count = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = ~m;
        seed  = IN_W'($urandom);
        count = (IN_W+1)'($urandom);
    endtask

    task automatic watch(input int limit, output int done_cyc, output int pulses,
                         output bit busy_seen);
        done_cyc = -1; pulses = 0; busy_seen = 1'b0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (busy) busy_seen = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        checks += 3;
        if (x_out !== '0)     begin errors++; $display("FAIL reset_x got %h want 0", x_out); end
        if (signature !== '0) begin errors++; $display("FAIL reset_sig got %h want 0", signature); end
        if (vec_idx !== '0)   begin errors++; $display("FAIL reset_idx got %0d want 0", vec_idx); end
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_counter_run;
        int dc, p; bit bs;
        zsel = 1'b0; z_const = 23'h000001;
        start_run(1'b0, 21'h0, 22'd3);
        watch(20, dc, p, bs);
        checks += 5;
        if (signature !== 23'h000007) begin errors++; $display("FAIL cnt_sig got %h want 000007", signature); end
        if (vec_idx !== 22'd3)        begin errors++; $display("FAIL cnt_idx got %0d want 3", vec_idx); end
        if (x_out !== 21'h000003)     begin errors++; $display("FAIL cnt_x got %h want 000003", x_out); end
        if (dc != 10)                 begin errors++; $display("FAIL cnt_done_cycle got %0d want 10", dc); end
        if (p != 1)                   begin errors++; $display("FAIL cnt_pulses got %0d want 1", p); end
    endtask

    task automatic test_lfsr_step;
        int dc, p; bit bs;
        zsel = 1'b1;
        start_run(1'b1, 21'h100000, 22'd1);
        watch(10, dc, p, bs);
        checks++;
        if (x_out !== 21'h000005) begin errors++; $display("FAIL lfsr_step got %h want 000005", x_out); end
        start_run(1'b1, 21'h0, 22'd1);
        checks++;
        if (x_out !== 21'h000001) begin errors++; $display("FAIL lfsr_zero_seed got %h want 000001", x_out); end
        watch(10, dc, p, bs);
        checks++;
        if (x_out !== 21'h000002) begin errors++; $display("FAIL lfsr_after_zero got %h want 000002", x_out); end
    endtask

    task automatic test_zero_count;
        int dc, p; bit bs;
        zsel = 1'b1;
        start_run(1'b0, 21'h0abcde, 22'd0);
        watch(8, dc, p, bs);
        checks += 5;
        if (dc != 1)          begin errors++; $display("FAIL zero_done_cycle got %0d want 1", dc); end
        if (p != 1)           begin errors++; $display("FAIL zero_pulses got %0d want 1", p); end
        if (bs)               begin errors++; $display("FAIL zero_busy got 1 want 0"); end
        if (signature !== '0) begin errors++; $display("FAIL zero_sig got %h want 0", signature); end
        if (x_out !== 21'h0abcde) begin errors++; $display("FAIL zero_x got %h want 0abcde", x_out); end
    endtask

    task automatic test_abort;
        logic [OUT_W-1:0] es; logic [IN_W-1:0] ex; int ei, dc, p; bit bs;
        zsel = 1'b1;
        // abort in the SETTLE of vector 2 (cycle 4)
        start_run(1'b0, 21'h01234, 22'd5);
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        model(1'b0, 21'h01234, 1, es, ex, ei);
        checks += 4;
        if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        if (vec_idx !== 22'(ei)) begin errors++; $display("FAIL abort_idx got %0d want %0d", vec_idx, ei); end
        if (signature !== es)  begin errors++; $display("FAIL abort_sig got %h want %h", signature, es); end
        if (x_out !== ex)      begin errors++; $display("FAIL abort_x got %h want %h", x_out, ex); end
        watch(20, dc, p, bs);
        checks += 2;
        if (p != 0)           begin errors++; $display("FAIL abort_done got %0d pulses want 0", p); end
        if (signature !== es) begin errors++; $display("FAIL abort_hold got %h want %h", signature, es); end
        // abort during the first SAMPLE (cycle 3) must win over the update
        start_run(1'b1, 21'h0f00d, 22'd5);
        repeat (2) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks += 3;
        if (vec_idx !== '0)      begin errors++; $display("FAIL abort_sample_idx got %0d want 0", vec_idx); end
        if (signature !== '0)    begin errors++; $display("FAIL abort_sample_sig got %h want 0", signature); end
        if (x_out !== 21'h0f00d) begin errors++; $display("FAIL abort_sample_x got %h want 0f00d", x_out); end
    endtask

    task automatic test_busy_start;
        logic [OUT_W-1:0] es; logic [IN_W-1:0] ex; int ei, dc, p; bit bs;
        zsel = 1'b1;
        start_run(1'b0, 21'h00010, 22'd4);
        seed = 21'h00555; count = 22'd2; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        watch(30, dc, p, bs);
        model(1'b0, 21'h00010, 4, es, ex, ei);
        checks += 5;
        if (dc != 12)          begin errors++; $display("FAIL busy_start_done_cycle got %0d want 12", dc); end
        if (p != 1)            begin errors++; $display("FAIL busy_start_pulses got %0d want 1", p); end
        if (signature !== es)  begin errors++; $display("FAIL busy_start_sig got %h want %h", signature, es); end
        if (x_out !== ex)      begin errors++; $display("FAIL busy_start_x got %h want %h", x_out, ex); end
        if (vec_idx !== 22'(ei)) begin errors++; $display("FAIL busy_start_idx got %0d want %0d", vec_idx, ei); end
    endtask

    task automatic test_random;
        logic [OUT_W-1:0] es; logic [IN_W-1:0] ex, s; int ei, dc, p, n; bit bs; logic m;
        for (int r = 0; r < 10; r++) begin
            zsel = 1'b1;
            m = 1'($urandom);
            s = (r == 3) ? '0 : IN_W'($urandom);
            n = $urandom_range(0, 12);
            start_run(m, s, (IN_W+1)'(n));
            watch(n * (SC + 1) + 6, dc, p, bs);
            model(m, s, n, es, ex, ei);
            checks += 6;
            if (dc != 1 + n * (SC + 1)) begin errors++; $display("FAIL rand%0d_done_cycle got %0d want %0d", r, dc, 1 + n * (SC + 1)); end
            if (p != 1)                 begin errors++; $display("FAIL rand%0d_pulses got %0d want 1", r, p); end
            if (bs != (n != 0))         begin errors++; $display("FAIL rand%0d_busy got %0d want %0d", r, bs, n != 0); end
            if (signature !== es)       begin errors++; $display("FAIL rand%0d_sig got %h want %h", r, signature, es); end
            if (x_out !== ex)           begin errors++; $display("FAIL rand%0d_x got %h want %h", r, x_out, ex); end
            if (vec_idx !== 22'(ei))    begin errors++; $display("FAIL rand%0d_idx got %0d want %0d", r, vec_idx, ei); end
        end
    endtask

    task automatic test_mid_run_reset;
        int dc, p; bit bs;
        zsel = 1'b1;
        start_run(1'b0, 21'h00777, 22'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3 rst_n = 1'b0;
        #1;
        checks += 5;
        if (x_out !== '0)     begin errors++; $display("FAIL midreset_x got %h want 0", x_out); end
        if (signature !== '0) begin errors++; $display("FAIL midreset_sig got %h want 0", signature); end
        if (vec_idx !== '0)   begin errors++; $display("FAIL midreset_idx got %0d want 0", vec_idx); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        if (done !== 1'b0)    begin errors++; $display("FAIL midreset_done got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        start_run(1'b0, 21'h00007, 22'd1);
        watch(8, dc, p, bs);
        checks += 2;
        if (dc != 4)             begin errors++; $display("FAIL postreset_done_cycle got %0d want 4", dc); end
        if (x_out !== 21'h00008) begin errors++; $display("FAIL postreset_x got %h want 00008", x_out); end
    endtask

    initial begin
        #12 test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_counter_run;
        test_lfsr_step;
        test_zero_count;
        test_abort;
        test_busy_start;
        test_random;
        test_mid_run_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
